// File: rtl/sa_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sa_pkg
//  Purpose  : Shared types and helpers for the systolic-array sequencer.
//             - sa_seq_state_t : sequencer state encoding
//             - skew_depth     : extra delay applied to one operand lane
//  Revision : 1.0  initial release
// ============================================================================
package sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sa_seq_state_t;

    // Lane n (the first row/column of the array) is undelayed; every lane
    // further from it waits one more advancing cycle.
    function automatic int skew_depth(input int lane, input int n);
        return n - lane;
    endfunction

endpackage : sa_pkg
`default_nettype wire

// File: rtl/sa_skew_line.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sa_skew_line
//  Purpose  : Enable-gated shift register used to skew one operand lane.
//             Latency is DEPTH+1 enabled cycles; DEPTH=0 is a single
//             registered pass-through.
//  Ports    : clk, rst (async, active-high)
//             i_en  - advance the line by one position
//             i_d   - lane value pushed on an enabled cycle
//             o_q   - oldest value in the line
//  Revision : 1.0  initial release
// ============================================================================
module sa_skew_line
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic [DATA_WIDTH-1:0] o_q
);

    logic [DATA_WIDTH-1:0] r_sr [0:DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else if (i_en) begin
            r_sr[0] <= i_d;
            for (int i = 1; i <= DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[DEPTH];

endmodule : sa_skew_line
`default_nettype wire

// File: rtl/sa_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sa_sequencer
//  Purpose  : Feeds one matrix tile into the systolic array and drains the
//             result rows. Applies the diagonal operand skew, drives the
//             array enable and per-PE clear/latch strobes, then walks the
//             one-hot row select and streams rows over valid/ready.
//  Ports    : clk, rst (async, active-high)
//             start/k_len           - command (sampled in IDLE)
//             busy/done             - command status
//             op_valid/op_ready     - operand beat handshake (a_vec, b_vec)
//             sa_en, sa_clc         - array enable and clear/latch strobes
//             sa_row_in, sa_col_in  - skewed operands into the array
//             sa_row_out_valid      - one-hot row select
//             sa_row_out            - selected result row from the array
//             out_valid/out_ready   - result row handshake (out_data, out_row)
//  Revision : 1.0  initial release
// ============================================================================
module sa_sequencer
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ROW    = 16,
    parameter int NUM_COL    = 16,
    parameter int K_WIDTH    = 16,
    parameter int PE_LAT     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [K_WIDTH-1:0]                    k_len,
    output logic                                  busy,
    output logic                                  done,
    input  logic                                  op_valid,
    output logic                                  op_ready,
    input  logic [NUM_ROW:1][DATA_WIDTH-1:0]      a_vec,
    input  logic [NUM_COL:1][DATA_WIDTH-1:0]      b_vec,
    output logic                                  sa_en,
    output logic [NUM_ROW:1][NUM_COL:1]           sa_clc,
    output logic [NUM_ROW:1][DATA_WIDTH-1:0]      sa_row_in,
    output logic [NUM_COL:1][DATA_WIDTH-1:0]      sa_col_in,
    output logic [NUM_ROW:1]                      sa_row_out_valid,
    input  logic [NUM_COL:1][DATA_WIDTH-1:0]      sa_row_out,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NUM_COL:1][DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(NUM_ROW+1)-1:0]          out_row
);

    // Advance counter must hold K plus the full flush without wrapping.
    localparam int c_t_width = K_WIDTH + $clog2(NUM_ROW + NUM_COL + PE_LAT);
    localparam int c_t_pad   = c_t_width - K_WIDTH;
    localparam int c_row_w   = $clog2(NUM_ROW + 1);

    localparam logic [c_t_width-1:0] c_t_one    = c_t_width'(1);
    localparam logic [c_t_width-1:0] c_pe_lat   = c_t_width'(PE_LAT);
    localparam logic [c_t_width-1:0] c_flush_m1 = c_t_width'(NUM_ROW + NUM_COL + PE_LAT - 3);
    localparam logic [c_row_w-1:0]   c_row_one  = c_row_w'(1);
    localparam logic [c_row_w-1:0]   c_row_top  = c_row_w'(NUM_ROW);

    sa_seq_state_t                     r_state;
    sa_seq_state_t                     w_state_nxt;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_op_ready;
    logic                              r_out_valid;
    logic [K_WIDTH-1:0]                r_k;
    logic [c_t_width-1:0]              r_t;
    logic [c_row_w-1:0]                r_row;

    logic [c_t_width-1:0]              w_k_ext;
    logic [c_t_width-1:0]              w_k_last;
    logic [c_t_width-1:0]              w_flush_last;
    logic [c_t_width-1:0]              w_clc_base;
    logic [c_t_width-1:0]              w_clc_rel;
    logic                              w_clc_ge;
    logic                              w_beat;
    logic                              w_adv;
    logic [NUM_ROW:1][DATA_WIDTH-1:0]  w_row_push;
    logic [NUM_COL:1][DATA_WIDTH-1:0]  w_col_push;

    // ------------------------------------------------------------------
    // Advance control: the array and the skew lines move together, so a
    // stalled beat freezes both and the diagonal stays aligned.
    // ------------------------------------------------------------------
    assign w_beat = r_op_ready & op_valid;
    assign w_adv  = w_beat | (r_state == ST_FLUSH);
    assign sa_en  = w_adv;

    assign w_k_ext      = {{c_t_pad{1'b0}}, r_k};
    assign w_k_last     = w_k_ext - c_t_one;
    assign w_flush_last = w_k_ext + c_flush_m1;

    // Strobe for PE (r,c) fires at t = K-1+PE_LAT + skew(r) + skew(c).
    // Subtract the common base once so each PE only compares a constant.
    assign w_clc_base = w_k_last + c_pe_lat;
    assign w_clc_ge   = (r_t >= w_clc_base);
    assign w_clc_rel  = r_t - w_clc_base;

    // Flush pushes zeros behind the last real beat.
    assign w_row_push = (r_state == ST_FEED) ? a_vec : '0;
    assign w_col_push = (r_state == ST_FEED) ? b_vec : '0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (k_len != '0) ? ST_FEED : ST_DONE;
                end
            end
            ST_FEED: begin
                if (w_beat && (r_t == w_k_last)) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_t == w_flush_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_out_valid && out_ready && (r_row == c_row_one)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_op_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_k         <= '0;
            r_t         <= '0;
            r_row       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt == ST_FEED) || (w_state_nxt == ST_FLUSH) ||
                           (w_state_nxt == ST_DRAIN);
            r_done      <= (w_state_nxt == ST_DONE);
            r_op_ready  <= (w_state_nxt == ST_FEED);
            r_out_valid <= (w_state_nxt == ST_DRAIN);

            if ((r_state == ST_IDLE) && start) begin
                r_k <= k_len;
                r_t <= '0;
            end else if (w_adv) begin
                r_t <= r_t + c_t_one;
            end

            // Row index is zero outside DRAIN so the one-hot select and
            // out_row are quiet without extra gating.
            if (w_state_nxt == ST_DRAIN) begin
                if (r_state != ST_DRAIN) begin
                    r_row <= c_row_top;
                end else if (out_ready) begin
                    r_row <= r_row - c_row_one;
                end
            end else begin
                r_row <= '0;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign op_ready  = r_op_ready;
    assign out_valid = r_out_valid;
    assign out_row   = r_row;
    // The array latches hold the selected row, so a direct pass-through is
    // stable under backpressure.
    assign out_data  = r_out_valid ? sa_row_out : '0;

    // ------------------------------------------------------------------
    // Skew lines
    // ------------------------------------------------------------------
    for (genvar gr = 1; gr <= NUM_ROW; gr++) begin : g_row_skew
        sa_skew_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (skew_depth(gr, NUM_ROW))
        ) u_row_line (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_adv),
            .i_d  (w_row_push[gr]),
            .o_q  (sa_row_in[gr])
        );
    end

    for (genvar gc = 1; gc <= NUM_COL; gc++) begin : g_col_skew
        sa_skew_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (skew_depth(gc, NUM_COL))
        ) u_col_line (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_adv),
            .i_d  (w_col_push[gc]),
            .o_q  (sa_col_in[gc])
        );
    end

    // ------------------------------------------------------------------
    // Per-PE clear/latch strobes and one-hot row select
    // ------------------------------------------------------------------
    for (genvar gr = 1; gr <= NUM_ROW; gr++) begin : g_clc_row
        for (genvar gc = 1; gc <= NUM_COL; gc++) begin : g_clc_col
            localparam logic [c_t_width-1:0] c_off =
                c_t_width'(skew_depth(gr, NUM_ROW) + skew_depth(gc, NUM_COL));
            assign sa_clc[gr][gc] = w_adv & w_clc_ge & (w_clc_rel == c_off);
        end
    end

    for (genvar gr = 1; gr <= NUM_ROW; gr++) begin : g_row_sel
        assign sa_row_out_valid[gr] = (r_row == c_row_w'(gr));
    end

endmodule : sa_sequencer
`default_nettype wire

// File: tb/tb_sa_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sa_sequencer
//  Purpose  : Directed self-checking bench for sa_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sa_sequencer;

    localparam int DW = 8;
    localparam int NR = 16;
    localparam int NC = 16;
    localparam int KW = 16;
    localparam int PL = 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [KW-1:0]             k_len;
    logic                      busy;
    logic                      done;
    logic                      op_valid;
    logic                      op_ready;
    logic [NR:1][DW-1:0]       a_vec;
    logic [NC:1][DW-1:0]       b_vec;
    logic                      sa_en;
    logic [NR:1][NC:1]         sa_clc;
    logic [NR:1][DW-1:0]       sa_row_in;
    logic [NC:1][DW-1:0]       sa_col_in;
    logic [NR:1]               sa_row_out_valid;
    logic [NC:1][DW-1:0]       sa_row_out;
    logic                      out_valid;
    logic                      out_ready;
    logic [NC:1][DW-1:0]       out_data;
    logic [4:0]                out_row;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sa_sequencer #(
        .DATA_WIDTH (DW),
        .NUM_ROW    (NR),
        .NUM_COL    (NC),
        .K_WIDTH    (KW),
        .PE_LAT     (PL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .k_len            (k_len),
        .busy             (busy),
        .done             (done),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .a_vec            (a_vec),
        .b_vec            (b_vec),
        .sa_en            (sa_en),
        .sa_clc           (sa_clc),
        .sa_row_in        (sa_row_in),
        .sa_col_in        (sa_col_in),
        .sa_row_out_valid (sa_row_out_valid),
        .sa_row_out       (sa_row_out),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_row          (out_row)
    );

    // Array result model: PE (r,c) holds ((r-1)<<4)|(c-1).
    always_comb begin
        sa_row_out = '0;
        for (int r = 1; r <= NR; r++) begin
            if (sa_row_out_valid[r]) begin
                for (int c = 1; c <= NC; c++) begin
                    sa_row_out[c] = DW'(((r - 1) << 4) | (c - 1));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command recording (filled by run_cmd, judged by the test tasks).
    // lane_at[n] is the lane value in the n-th advancing cycle, i.e. the
    // value presented after n+1 advances.
    // ------------------------------------------------------------------
    logic [DW-1:0]       r16_at [0:63];
    logic [DW-1:0]       r1_at  [0:63];
    logic [DW-1:0]       c16_at [0:63];
    logic [DW-1:0]       c1_at  [0:63];
    int                  clc_cnt [1:NR][1:NC];
    int                  clc_t   [1:NR][1:NC];
    int                  clc_n   [1:NR][1:NC];
    int                  rows;
    logic [4:0]          row_seq  [0:31];
    logic [NC:1][DW-1:0] data_seq [0:31];
    int                  done_n;
    int                  done_cnt;
    bit                  timed_out;
    bit                  busy0;
    bit                  gap_en;
    bit                  gap_bad;
    logic [DW-1:0]       gap_r16, gap_r15, gap_c16, gap_c15;
    bit                  hold_bad;
    int                  held_cycles;
    logic [4:0]          held_row;
    logic [NC:1][DW-1:0] held_data;

    task automatic run_cmd(input int k, input int stall_after, input int stall_len,
                           input int hold);
        int  beats    = 0;
        int  adv      = 0;
        int  stalled  = 0;
        bit  in_gap   = 0;
        bit  prev_gap = 0;
        for (int i = 0; i < 64; i++) begin
            r16_at[i] = 'x; r1_at[i] = 'x; c16_at[i] = 'x; c1_at[i] = 'x;
        end
        for (int r = 1; r <= NR; r++)
            for (int c = 1; c <= NC; c++) begin
                clc_cnt[r][c] = 0; clc_t[r][c] = -1; clc_n[r][c] = -1;
            end
        rows = 0; done_n = -1; done_cnt = 0; timed_out = 0; busy0 = 0;
        gap_en = 0; gap_bad = 0; hold_bad = 0; held_cycles = 0;
        start = 1'b1;
        k_len = KW'(k);
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (adv >= 1 && adv <= 64) begin
                r16_at[adv-1] = sa_row_in[16];
                r1_at[adv-1]  = sa_row_in[1];
                c16_at[adv-1] = sa_col_in[16];
                c1_at[adv-1]  = sa_col_in[1];
            end
            in_gap = op_ready && (beats == stall_after) && (stalled < stall_len);
            if (in_gap) begin
                op_valid = 1'b0;
                stalled++;
            end else if (op_ready && beats < k) begin
                op_valid = 1'b1;
                a_vec    = {NR{DW'(beats + 1)}};
                b_vec    = {NC{DW'(beats + 1)}};
            end else begin
                op_valid = 1'b0;
            end
            out_ready = !(out_valid && held_cycles < hold);
            #1;
            if (n == 0) busy0 = busy;
            if (in_gap && stalled == 1) begin
                gap_r16 = sa_row_in[16]; gap_r15 = sa_row_in[15];
                gap_c16 = sa_col_in[16]; gap_c15 = sa_col_in[15];
            end
            if (in_gap || prev_gap) begin
                if (in_gap && sa_en) gap_en = 1;
                if (sa_row_in[16] !== gap_r16 || sa_row_in[15] !== gap_r15 ||
                    sa_col_in[16] !== gap_c16 || sa_col_in[15] !== gap_c15)
                    gap_bad = 1;
            end
            prev_gap = in_gap;
            if (op_valid && op_ready) beats++;
            for (int r = 1; r <= NR; r++)
                for (int c = 1; c <= NC; c++)
                    if (sa_clc[r][c] === 1'b1) begin
                        if (clc_cnt[r][c] == 0) begin
                            clc_t[r][c] = adv;
                            clc_n[r][c] = n;
                        end
                        clc_cnt[r][c]++;
                    end
            if (out_valid) begin
                if (out_ready) begin
                    if (rows < 32) begin
                        row_seq[rows]  = out_row;
                        data_seq[rows] = out_data;
                    end
                    rows++;
                end else begin
                    if (held_cycles == 0) begin
                        held_row  = out_row;
                        held_data = out_data;
                    end else if (out_row !== held_row || out_data !== held_data) begin
                        hold_bad = 1;
                    end
                    held_cycles++;
                end
            end
            if (done) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
            end
            if (sa_en) adv++;
            @(negedge clk);
            if (done_n >= 0 && n >= done_n + 2) break;
        end
        timed_out = (done_n < 0);
        op_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; k_len = '0; op_valid = 1'b0;
        a_vec = '0; b_vec = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if ({busy, done, op_ready, sa_en, out_valid} !== 5'b0) begin
            $display("FAIL reset_status: got %b want 00000", {busy, done, op_ready, sa_en, out_valid});
        end else n_pass++;
        n_total++;
        if (sa_clc !== '0 || sa_row_out_valid !== '0 || out_row !== '0) begin
            $display("FAIL reset_strobes: clc %h sel %h row %0d want 0", sa_clc, sa_row_out_valid, out_row);
        end else n_pass++;
        n_total++;
        if (sa_row_in !== '0 || sa_col_in !== '0 || out_data !== '0) begin
            $display("FAIL reset_lanes: row %h col %h data %h want 0", sa_row_in, sa_col_in, out_data);
        end else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_skew_strobe();
        int bad_pe = 0;
        int bad_rows = 0;
        logic [NC:1][DW-1:0] exp_row;
        run_cmd(3, 99, 0, 0);
        n_total++;
        if (timed_out) $display("FAIL k3_timeout: done not seen within budget");
        else n_pass++;
        n_total++;
        if (busy0 !== 1'b1) $display("FAIL k3_busy: got %b want 1", busy0);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (r16_at[i] !== DW'(i + 1) || c16_at[i] !== DW'(i + 1))
                $display("FAIL k3_lane16_cyc%0d: row %0d col %0d want %0d", i, r16_at[i], c16_at[i], i + 1);
            else n_pass++;
            n_total++;
            if (r1_at[15 + i] !== DW'(i + 1) || c1_at[15 + i] !== DW'(i + 1))
                $display("FAIL k3_lane1_cyc%0d: row %0d col %0d want %0d", 15 + i, r1_at[15 + i], c1_at[15 + i], i + 1);
            else n_pass++;
        end
        n_total++;
        if (r16_at[3] !== '0 || r1_at[14] !== '0)
            $display("FAIL k3_lane_fill: lane16@3 %0d lane1@14 %0d want 0", r16_at[3], r1_at[14]);
        else n_pass++;
        n_total++;
        if (clc_t[16][16] !== 3) $display("FAIL k3_clc_16_16: got t=%0d want 3", clc_t[16][16]);
        else n_pass++;
        n_total++;
        if (clc_t[1][1] !== 33) $display("FAIL k3_clc_1_1: got t=%0d want 33", clc_t[1][1]);
        else n_pass++;
        n_total++;
        if (clc_t[16][1] !== 18) $display("FAIL k3_clc_16_1: got t=%0d want 18", clc_t[16][1]);
        else n_pass++;
        for (int r = 1; r <= NR; r++)
            for (int c = 1; c <= NC; c++)
                if (clc_cnt[r][c] != 1) bad_pe++;
        n_total++;
        if (bad_pe != 0) $display("FAIL k3_clc_once: %0d PEs pulsed other than once, want 0", bad_pe);
        else n_pass++;
        n_total++;
        if (done_n !== 50) $display("FAIL k3_length: done at %0d want 50", done_n);
        else n_pass++;
        n_total++;
        if (done_cnt !== 1) $display("FAIL k3_done_pulse: got %0d pulses want 1", done_cnt);
        else n_pass++;
        n_total++;
        if (rows !== 16) $display("FAIL k3_rows: got %0d want 16", rows);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            for (int c = 1; c <= NC; c++) exp_row[c] = DW'(((15 - i) << 4) | (c - 1));
            if (row_seq[i] !== 5'(16 - i) || data_seq[i] !== exp_row) bad_rows++;
        end
        n_total++;
        if (bad_rows != 0) $display("FAIL k3_row_order: %0d rows wrong, want 0", bad_rows);
        else n_pass++;
    endtask

    task automatic test_stall();
        run_cmd(4, 2, 2, 0);
        n_total++;
        if (timed_out) $display("FAIL stall_timeout: done not seen within budget");
        else n_pass++;
        n_total++;
        if (gap_en !== 1'b0) $display("FAIL stall_en: sa_en got 1 in gap want 0");
        else n_pass++;
        n_total++;
        if (gap_bad !== 1'b0 || gap_r16 !== 8'd2 || gap_r15 !== 8'd1 || gap_c16 !== 8'd2 || gap_c15 !== 8'd1)
            $display("FAIL stall_freeze: moved %b r16 %0d r15 %0d c16 %0d c15 %0d want 0 2 1 2 1",
                     gap_bad, gap_r16, gap_r15, gap_c16, gap_c15);
        else n_pass++;
        n_total++;
        if (clc_n[16][16] !== 6 || clc_t[16][16] !== 4)
            $display("FAIL stall_clc_16_16: cycle %0d t %0d want 6 4", clc_n[16][16], clc_t[16][16]);
        else n_pass++;
        n_total++;
        if (clc_n[1][1] !== 36 || clc_t[1][1] !== 34)
            $display("FAIL stall_clc_1_1: cycle %0d t %0d want 36 34", clc_n[1][1], clc_t[1][1]);
        else n_pass++;
        n_total++;
        if (r16_at[3] !== 8'd4) $display("FAIL stall_lane16_last: got %0d want 4", r16_at[3]);
        else n_pass++;
    endtask

    task automatic test_drain_backpressure();
        run_cmd(2, 99, 0, 3);
        n_total++;
        if (timed_out) $display("FAIL drain_timeout: done not seen within budget");
        else n_pass++;
        n_total++;
        if (held_cycles !== 3 || hold_bad !== 1'b0 || held_row !== 5'd16)
            $display("FAIL drain_hold: cycles %0d moved %b row %0d want 3 0 16", held_cycles, hold_bad, held_row);
        else n_pass++;
        n_total++;
        if (rows !== 16 || row_seq[0] !== 5'd16 || row_seq[15] !== 5'd1 || data_seq[0] !== held_data)
            $display("FAIL drain_order: rows %0d first %0d last %0d want 16 16 1", rows, row_seq[0], row_seq[15]);
        else n_pass++;
        n_total++;
        if (done_n !== 52 || done_cnt !== 1)
            $display("FAIL drain_done: at %0d count %0d want 52 1", done_n, done_cnt);
        else n_pass++;
    endtask

    task automatic test_k_zero();
        int  dn  = -1;
        int  dc  = 0;
        bit  act = 0;
        start = 1'b1;
        k_len = '0;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            #1;
            if (done) begin
                dc++;
                if (dn < 0) dn = n;
            end
            if (sa_en || sa_clc != '0 || out_valid || busy || op_ready) act = 1;
            @(negedge clk);
        end
        n_total++;
        if (dc !== 1 || dn < 0 || dn > 1)
            $display("FAIL kzero_done: count %0d at %0d want 1 within 2 cycles", dc, dn);
        else n_pass++;
        n_total++;
        if (act !== 1'b0) $display("FAIL kzero_activity: got 1 want 0");
        else n_pass++;
    endtask

    task automatic test_reset_in_flush();
        int late_done = 0;
        start = 1'b1;
        k_len = KW'(3);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op_valid = 1'b1;
            a_vec    = {NR{DW'(i + 1)}};
            b_vec    = {NC{DW'(i + 1)}};
            @(negedge clk);
        end
        op_valid = 1'b0;
        #1;
        n_total++;
        if (sa_clc[16][16] !== 1'b1 || sa_en !== 1'b1 || sa_row_in[16] !== 8'd3)
            $display("FAIL rst_pre: clc %b en %b lane %0d want 1 1 3", sa_clc[16][16], sa_en, sa_row_in[16]);
        else n_pass++;
        #1;
        rst = 1'b1;
        #1;
        n_total++;
        if (sa_clc !== '0 || sa_en !== 1'b0 || sa_row_in !== '0 || sa_col_in !== '0)
            $display("FAIL rst_async_array: clc %h en %b row %h col %h want 0", sa_clc, sa_en, sa_row_in, sa_col_in);
        else n_pass++;
        n_total++;
        if ({busy, done, op_ready, out_valid} !== 4'b0 || out_row !== '0 || sa_row_out_valid !== '0)
            $display("FAIL rst_async_status: got %b row %0d want 0000 0", {busy, done, op_ready, out_valid}, out_row);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        n_total++;
        if (late_done !== 0) $display("FAIL rst_no_done: got %0d active cycles want 0", late_done);
        else n_pass++;
        run_cmd(3, 99, 0, 0);
        n_total++;
        if (timed_out || done_cnt !== 1 || rows !== 16 || clc_t[1][1] !== 33)
            $display("FAIL rst_restart: timeout %b done %0d rows %0d clc11 %0d want 0 1 16 33",
                     timed_out, done_cnt, rows, clc_t[1][1]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_skew_strobe();
        test_stall();
        test_drain_backpressure();
        test_k_zero();
        test_reset_in_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute safety net against a hung simulation.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_sa_sequencer
`default_nettype wire

// File: doc/sa_sequencer.md
# sa_sequencer

Drives the systolic array's input side and drains its result side for one matrix tile per command. Accepts one K-step operand beat per cycle: one column of A, one element per array row, and one row of B, one element per array column. It applies the diagonal skew the array requires and generates the global enable and the per-PE clear/latch strobes. It then walks the one-hot row-select to stream the latched results out row by row over a valid/ready port. It sits between the operand buffers/DMA and the array, and owns all array timing.

## Interface
- `data_width`, 8: operand and result lane width.
- `num_row`, 16: array rows. Row `num_row` is the first (top) row.
- `num_col`, 16: array columns. Column `num_col` is the first (left) column.
- `k_width`, 16: width of `k_len`.
- `pe_lat`, 1: PE cycles from the last operand arriving at a PE to its result being valid.
- `clk` in 1: clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `start` in 1: command pulse. Sampled only in IDLE.
- `k_len` in `k_width`: inner dimension K. Latched on accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until DONE.
- `done` out 1: one-cycle pulse at command end.
- `op_valid`/`op_ready` in/out 1: operand beat handshake.
- `a_vec` in `[num_row:1][data_width]`: A column, one element per row.
- `b_vec` in `[num_col:1][data_width]`: B row, one element per column.
- `sa_en` out 1: array enable.
- `sa_clc` out `[num_row:1][num_col:1]`: per-PE clear/latch strobe.
- `sa_row_in` out `[num_row:1][data_width]`: skewed row operands into the array.
- `sa_col_in` out `[num_col:1][data_width]`: skewed column operands into the array.
- `sa_row_out_valid` out `[num_row:1]`: one-hot row select to the array.
- `sa_row_out` in `[num_col:1][data_width]`: selected row of array results.
- `out_valid`/`out_ready` out/in 1: result row handshake.
- `out_data` out `[num_col:1][data_width]`: result row.
- `out_row` out `$clog2(num_row+1)`: index of the result row on `out_data`.

## Operation
- FSM states: IDLE → FEED → FLUSH → DRAIN → DONE → IDLE.
- IDLE, `start` with `k_len`≠0: latch K, clear the advance counter `t`, go to FEED.
- IDLE, `start` with `k_len`=0: go to DONE directly, with no array activity.
- FEED:
  - `op_ready`=1 and `sa_en`=`op_valid`.
  - Each accepted beat pushes `a_vec`/`b_vec` into the skew lines and increments `t`.
  - After K beats, go to FLUSH.
  - A low `op_valid` freezes the array and the skew lines together, so skew alignment is preserved across stalls.
- FLUSH:
  - `sa_en`=1 every cycle and zeros are pushed into the skew lines.
  - Length is `num_row+num_col+pe_lat-2` cycles, then go to DRAIN.
- Skew:
  - Row lane r is delayed by `num_row-r` advancing cycles.
  - Column lane c is delayed by `num_col-c` advancing cycles.
  - Lanes `num_row` and `num_col` are undelayed registered pass-through (delay 0).
- Strobe: `sa_clc[r][c]`=1 exactly in the cycle where `sa_en`=1 and `t == K-1+(num_row-r)+(num_col-c)+pe_lat`. All strobes therefore fall inside FLUSH.
- DRAIN:
  - Row index runs `num_row` down to 1.
  - `sa_row_out_valid` is one-hot on the current row.
  - `out_data`=`sa_row_out`, combinational pass-through. `out_valid`=1 and `out_row` = current index.
  - The index advances on `out_valid&&out_ready`. After row 1 is accepted, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while `busy` is ignored.

## Timing
- Reset values: every output is 0, including `sa_clc`, all lanes, `sa_row_out_valid`, `out_row`, `busy`, `done` and both ready/valid outputs. The FSM is in IDLE and the skew lines are zero.
- Reset mid-command: the array strobes drop immediately and the command is abandoned. No `done` pulse.
- Row lane r first shows beat 0 in advancing cycle `num_row-r`, counted from the first accepted beat.
- Minimum command length with no stalls: `1+K+(num_row+num_col+pe_lat-2)+num_row+1` cycles.
- `t` width is `k_width+$clog2(num_row+num_col+pe_lat)`. `t` never wraps.
- `out_valid` stays asserted under backpressure. `out_data` stays stable because `sa_row_out` is held by the array's latches.

## Structure
- Package `sa_pkg`:
  - state enum `sa_seq_state_t` (IDLE, FEED, FLUSH, DRAIN, DONE);
  - function `skew_depth(lane, n)` returning `n-lane`.
- Sub-module `sa_skew_line`:
  - parameters `data_width` and `depth`;
  - an enable-gated shift register;
  - `depth`=0 gives a single-register pass-through.
- Instantiated once per row lane and once per column lane.

## Test plan
- K=3, no stalls. Row beats are 1, 2, 3 on all lanes, and lanes in array order (`num_row` first) are checked → `sa_row_in[16]` = 1, 2, 3 in advancing cycles 0–2, and `sa_row_in[1]` = 1, 2, 3 in cycles 15–17. Column lanes are checked in array order (`num_col` first) → `sa_col_in[16]` = 1, 2, 3 in cycles 0–2, and `sa_col_in[1]` = 1, 2, 3 in cycles 15–17.
- K=3, `pe_lat`=1 → `sa_clc[16][16]` pulses at t=3 and `sa_clc[1][1]` at t=33. Each PE pulses exactly once.
- K=4 with `op_valid` low for 2 cycles after beat 1 → `sa_en`=0 during the gap, `sa_row_in` lanes are frozen during the gap, and strobe times shift by exactly 2 cycles.
- DRAIN with `out_ready` low for 3 cycles on row 16 → `out_row`=16 and `out_data` hold steady. Rows then arrive in order 16 down to 1, followed by `done`.
- `start` with `k_len`=0 → `done` 2 cycles later, while `sa_en`, `sa_clc` and `out_valid` stay 0.
- `rst` asserted in FLUSH → all outputs 0 asynchronously. A new `start` then completes normally.
